// File: rtl/seq_mantissa_alu_if.sv
// Handshake/data bundle for seq_mantissa_alu.
//   master: FP control side, drives start/op/a/b and watches busy/done/neg/result.
//   slave : the ALU itself.
// WIDTH must match the WIDTH of the ALU instance the bundle is attached to.
interface seq_mantissa_alu_if #(
  parameter int WIDTH = 28
);
  logic                 start;
  logic [1:0]           op;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic                 neg;
  logic [2*WIDTH-1:0]   result;

  modport master (output start, op, a, b, input busy, done, neg, result);
  modport slave  (input start, op, a, b, output busy, done, neg, result);
endinterface

// File: rtl/seq_mantissa_alu.sv
// Multi-cycle integer ALU for floating-point mantissa datapaths.
// add / sub finish in one cycle; mul is an unsigned shift-add that takes up to
// WIDTH steps (fewer with EARLY_EXIT once the remaining multiplier bits are 0).
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous, active-high; aborts any operation without a done pulse
//   bus   - slave side of seq_mantissa_alu_if:
//           start/op/a/b in; busy (state MUL), done (one-cycle, state DONE),
//           neg (sub a<b), result (2*WIDTH, held until the next completion)
module seq_mantissa_alu #(
  parameter int WIDTH      = 28,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  seq_mantissa_alu_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  logic [1:0]         state;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] result;
  logic               neg;

  // Next-step values of the multiply datapath
  logic [2*WIDTH-1:0] accNext;
  logic [WIDTH-1:0]   mplierNext;
  logic [CW-1:0]      cntNext;
  logic               mulLast;

  // Zero-extended operands for the 2*WIDTH-bit add/sub
  logic [2*WIDTH-1:0] aExt;
  logic [2*WIDTH-1:0] bExt;

  always_comb begin
    aExt       = {{WIDTH{1'b0}}, bus.a};
    bExt       = {{WIDTH{1'b0}}, bus.b};
    accNext    = mplier[0] ? (acc + mcand) : acc;
    mplierNext = mplier >> 1;
    cntNext    = cnt + CW'(1);
    // WIDTH steps is the hard cap; early exit only shortens it.
    mulLast    = (cntNext == CW'(WIDTH)) || (EARLY_EXIT && (mplierNext == '0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      result <= '0;
      neg    <= 1'b0;
    end else begin
      case (state)
        MUL: begin
          // start is ignored here; operands were captured at accept.
          acc    <= accNext;
          mcand  <= mcand << 1;
          mplier <= mplierNext;
          cnt    <= cntNext;
          if (mulLast) begin
            result <= accNext;
            state  <= DONE;
          end
        end
        default: begin  // IDLE or DONE: both accept a new start
          if (bus.start) begin
            case (bus.op)
              OP_ADD: begin
                result <= aExt + bExt;
                neg    <= 1'b0;
                state  <= DONE;
              end
              OP_SUB: begin
                result <= aExt - bExt;
                neg    <= (bus.a < bus.b);
                state  <= DONE;
              end
              OP_MUL: begin
                // result is left alone until the final step
                acc    <= '0;
                mcand  <= aExt;
                mplier <= bus.b;
                cnt    <= '0;
                neg    <= 1'b0;
                state  <= MUL;
              end
              default: begin
                result <= '0;
                neg    <= 1'b0;
                state  <= DONE;
              end
            endcase
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy   = (state == MUL);
  assign bus.done   = (state == DONE);
  assign bus.neg    = neg;
  assign bus.result = result;

endmodule

// File: tb/tb_seq_mantissa_alu.sv
module tb_seq_mantissa_alu;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   nChecks = 0;
  int   nErrors = 0;

  always #5 clk = ~clk;

  seq_mantissa_alu_if #(.WIDTH(28)) ifE ();
  seq_mantissa_alu_if #(.WIDTH(28)) ifF ();

  seq_mantissa_alu #(.WIDTH(28), .EARLY_EXIT(1'b1)) dutE (.clk(clk), .reset(reset), .bus(ifE.slave));
  seq_mantissa_alu #(.WIDTH(28), .EARLY_EXIT(1'b0)) dutF (.clk(clk), .reset(reset), .bus(ifF.slave));

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Launch one op on the EARLY_EXIT=1 instance and check its completion.
  task automatic runOp(input string tag, input logic [1:0] op, input logic [27:0] a,
                       input logic [27:0] b, input logic [55:0] expRes,
                       input logic expNeg, input int expBusy);
    int busyCnt = 0;
    int guard = 0;
    @(negedge clk);
    ifE.start = 1'b1; ifE.op = op; ifE.a = a; ifE.b = b;
    @(negedge clk);
    ifE.start = 1'b0;
    while (!ifE.done && guard < 100) begin
      if (ifE.busy) busyCnt++;
      guard++;
      @(negedge clk);
    end
    chk({tag, "_done"},   64'(ifE.done), 64'd1);
    chk({tag, "_busy"},   64'(busyCnt), 64'(expBusy));
    chk({tag, "_result"}, 64'(ifE.result), 64'(expRes));
    chk({tag, "_neg"},    64'(ifE.neg), 64'(expNeg));
    @(negedge clk);
    chk({tag, "_pulse"},  64'(ifE.done), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int busyCnt;
    int guard;
    int doneCnt;
    ifE.start = 1'b0; ifE.op = 2'b00; ifE.a = '0; ifE.b = '0;
    ifF.start = 1'b0; ifF.op = 2'b00; ifF.a = '0; ifF.b = '0;

    repeat (3) @(negedge clk);
    chk("rst_busy",   64'(ifE.busy), 64'd0);
    chk("rst_done",   64'(ifE.done), 64'd0);
    chk("rst_neg",    64'(ifE.neg), 64'd0);
    chk("rst_result", 64'(ifE.result), 64'd0);
    chk("rstF_state", 64'({ifF.busy, ifF.done}), 64'd0);
    reset = 1'b0;

    runOp("add",     2'b00, 28'hFFFFFFF, 28'hFFFFFFF, 56'h1FFFFFFE, 1'b0, 0);
    runOp("sub_neg", 2'b01, 28'd5, 28'd9, 56'hFFFFFFFFFFFFFC, 1'b1, 0);
    runOp("sub_pos", 2'b01, 28'd9, 28'd5, 56'd4, 1'b0, 0);
    runOp("rsvd",    2'b11, 28'd7, 28'd3, 56'd0, 1'b0, 0);
    runOp("mul3x5",  2'b10, 28'd3, 28'd5, 56'd15, 1'b0, 3);
    runOp("mulb0",   2'b10, 28'h1234, 28'd0, 56'd0, 1'b0, 1);
    runOp("mulfullE", 2'b10, 28'hFFFFFFF, 28'hFFFFFFF, 56'hFFFFFFE0000001, 1'b0, 28);
    runOp("mul_sm",  2'b10, 28'd2, 28'd1, 56'd2, 1'b0, 1);

    // Full-width multiply without early exit: always WIDTH steps
    @(negedge clk);
    ifF.start = 1'b1; ifF.op = 2'b10; ifF.a = 28'hFFFFFFF; ifF.b = 28'hFFFFFFF;
    @(negedge clk);
    ifF.start = 1'b0;
    busyCnt = 0; guard = 0;
    while (!ifF.done && guard < 100) begin
      if (ifF.busy) busyCnt++;
      guard++;
      @(negedge clk);
    end
    chk("mulfullF_done",   64'(ifF.done), 64'd1);
    chk("mulfullF_busy",   64'(busyCnt), 64'd28);
    chk("mulfullF_result", 64'(ifF.result), 64'hFFFFFFE0000001);

    // Small multiplier still takes WIDTH steps without early exit
    @(negedge clk);
    ifF.start = 1'b1; ifF.op = 2'b10; ifF.a = 28'd3; ifF.b = 28'd5;
    @(negedge clk);
    ifF.start = 1'b0;
    busyCnt = 0; guard = 0;
    while (!ifF.done && guard < 100) begin
      if (ifF.busy) busyCnt++;
      guard++;
      @(negedge clk);
    end
    chk("mul3x5F_busy",   64'(busyCnt), 64'd28);
    chk("mul3x5F_result", 64'(ifF.result), 64'd15);

    // start held high and operands toggled during MUL, then back-to-back sub
    @(negedge clk);
    ifE.start = 1'b1; ifE.op = 2'b10; ifE.a = 28'd3; ifE.b = 28'd5;
    @(negedge clk);
    busyCnt = 0; guard = 0;
    while (!ifE.done && guard < 100) begin
      if (ifE.busy) busyCnt++;
      ifE.op = 2'b00; ifE.a = 28'hABCDEF0 + 28'(guard); ifE.b = 28'h7654321;
      guard++;
      @(negedge clk);
    end
    chk("hold_done",   64'(ifE.done), 64'd1);
    chk("hold_busy",   64'(busyCnt), 64'd3);
    chk("hold_result", 64'(ifE.result), 64'd15);
    ifE.op = 2'b01; ifE.a = 28'd20; ifE.b = 28'd7;
    @(negedge clk);
    ifE.start = 1'b0;
    chk("b2b_done",   64'(ifE.done), 64'd1);
    chk("b2b_busy",   64'(ifE.busy), 64'd0);
    chk("b2b_result", 64'(ifE.result), 64'd13);
    chk("b2b_neg",    64'(ifE.neg), 64'd0);

    // Reset in the middle of a full-width multiply
    @(negedge clk);
    ifE.start = 1'b1; ifE.op = 2'b10; ifE.a = 28'hFFFFFFF; ifE.b = 28'hFFFFFFF;
    @(negedge clk);
    ifE.start = 1'b0;
    repeat (9) @(negedge clk);
    chk("abort_busy_pre", 64'(ifE.busy), 64'd1);
    chk("abort_res_pre",  64'(ifE.result), 64'd13);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy",   64'(ifE.busy), 64'd0);
    chk("abort_done",   64'(ifE.done), 64'd0);
    chk("abort_result", 64'(ifE.result), 64'd0);
    doneCnt = 0;
    repeat (30) begin
      if (ifE.done || ifE.busy) doneCnt++;
      @(negedge clk);
    end
    chk("abort_quiet", 64'(doneCnt), 64'd0);
    runOp("post_add", 2'b00, 28'd1, 28'd2, 56'd3, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
